// File: rtl/exe_alu_if.sv
// Execute-stage ALU bus: operands and decode fields in, result and strobes out.
// The master drives the operands; the slave is the exe_alu_unit.
interface exe_alu_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic [3:0]        alu_op;
  logic [5:0]        func;
  logic              dbl;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] ext_imm;

  logic [DATA_W-1:0] result;
  logic              zero;
  logic              overflow;
  logic [4:0]        operation;
  logic              lohi_write;
  logic              lo_read;
  logic              hi_read;
  logic              compare_op;
  logic              r_mem_to_reg;
  logic              read_from_mem;
  logic              write_to_mem;
  logic [ADDR_W-1:0] branch_addr;
  logic              fp_cond;

  modport master (
    output alu_op, func, dbl, shamt, op1, op2, pc_plus4, ext_imm,
    input  result, zero, overflow, operation, lohi_write, lo_read, hi_read,
           compare_op, r_mem_to_reg, read_from_mem, write_to_mem,
           branch_addr, fp_cond
  );

  modport slave (
    input  alu_op, func, dbl, shamt, op1, op2, pc_plus4, ext_imm,
    output result, zero, overflow, operation, lohi_write, lo_read, hi_read,
           compare_op, r_mem_to_reg, read_from_mem, write_to_mem,
           branch_addr, fp_cond
  );
endinterface

// File: rtl/exe_alu_unit.sv
// MIPS execute stage: ALU-control decode, 64-bit ALU, branch adder and FP condition flag.
// Define MULT_EN to build the MULT/MULTU multiplier; otherwise those functs decode as ADD.
module exe_alu_unit #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  exe_alu_if.slave   bus
);

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_NOR   = 5'd5,
    OP_SLT   = 5'd6,
    OP_SLTU  = 5'd7,
    OP_SLL   = 5'd8,
    OP_SRL   = 5'd9,
    OP_SRA   = 5'd10,
    OP_SLLV  = 5'd11,
    OP_SRLV  = 5'd12,
    OP_SRAV  = 5'd13,
    OP_LUI   = 5'd14,
    OP_MULT  = 5'd15,
    OP_MULTU = 5'd16,
    OP_CMP   = 5'd17
  } aluOp_e;

  aluOp_e            w_op;
  logic              w_ovfEn;
  logic              w_lohiWrite;
  logic              w_loRead;
  logic              w_hiRead;
  logic              w_compareOp;
  logic              w_memToReg;
  logic              w_readMem;
  logic              w_writeMem;

  logic [31:0]       w_a32;
  logic [31:0]       w_b32;
  logic [31:0]       w_sum32;
  logic [31:0]       w_diff32;
  logic [31:0]       w_sra32;
  logic [31:0]       w_srav32;
  logic [DATA_W-1:0] w_result;
  logic              w_zero;
  logic              w_addOvf;
  logic              w_subOvf;
  logic              r_fpCond;

  // Strobes default low so only the listed decodes ever raise them.
  always_comb begin
    w_op        = OP_ADD;
    w_ovfEn     = 1'b0;
    w_lohiWrite = 1'b0;
    w_loRead    = 1'b0;
    w_hiRead    = 1'b0;
    w_compareOp = 1'b0;
    w_memToReg  = 1'b0;
    w_readMem   = 1'b0;
    w_writeMem  = 1'b0;
    case (bus.alu_op)
      4'b0000: begin w_op = OP_ADD; w_ovfEn = 1'b1; end
      4'b0001: begin w_op = OP_SUB; w_ovfEn = 1'b1; end
      4'b0010: begin
        case (bus.func)
          6'h20: begin w_op = OP_ADD; w_ovfEn = 1'b1; end
          6'h21: w_op = OP_ADD;
          6'h22: begin w_op = OP_SUB; w_ovfEn = 1'b1; end
          6'h23: w_op = OP_SUB;
          6'h24: w_op = OP_AND;
          6'h25: w_op = OP_OR;
          6'h26: w_op = OP_XOR;
          6'h27: w_op = OP_NOR;
          6'h2A: w_op = OP_SLT;
          6'h2B: w_op = OP_SLTU;
          6'h00: w_op = OP_SLL;
          6'h02: w_op = OP_SRL;
          6'h03: w_op = OP_SRA;
          6'h04: w_op = OP_SLLV;
          6'h06: w_op = OP_SRLV;
          6'h07: w_op = OP_SRAV;
`ifdef MULT_EN
          6'h18: begin w_op = OP_MULT;  w_lohiWrite = 1'b1; end
          6'h19: begin w_op = OP_MULTU; w_lohiWrite = 1'b1; end
`endif
          6'h10: w_hiRead = 1'b1;
          6'h12: w_loRead = 1'b1;
          6'h0A: begin w_readMem = 1'b1; w_memToReg = 1'b1; end
          6'h0B: w_writeMem = 1'b1;
          default: w_op = OP_ADD;
        endcase
      end
      4'b0011: w_op = OP_AND;
      4'b0100: w_op = OP_OR;
      4'b0101: w_op = OP_XOR;
      4'b0110: w_op = OP_SLT;
      4'b0111: w_op = OP_SLTU;
      4'b1000: w_op = OP_LUI;
      4'b1001: begin
        if (bus.func == 6'h32) begin
          w_op        = OP_CMP;
          w_compareOp = 1'b1;
        end
      end
      default: w_op = OP_ADD;
    endcase
  end

  assign w_a32    = bus.op1[31:0];
  assign w_b32    = bus.op2[31:0];
  assign w_sum32  = w_a32 + w_b32;
  assign w_diff32 = w_a32 - w_b32;
  assign w_sra32  = $signed(w_b32) >>> bus.shamt;
  assign w_srav32 = $signed(w_b32) >>> bus.op1[4:0];

`ifdef MULT_EN
  logic [63:0] w_mulSigned;
  logic [63:0] w_mulUnsigned;

  assign w_mulSigned   = $signed({{32{w_a32[31]}}, w_a32}) * $signed({{32{w_b32[31]}}, w_b32});
  assign w_mulUnsigned = {32'h0, w_a32} * {32'h0, w_b32};
`endif

  // 32-bit operations leave the upper half of the result cleared.
  always_comb begin
    w_result = '0;
    case (w_op)
      OP_ADD:   w_result = {{(DATA_W-32){1'b0}}, w_sum32};
      OP_SUB:   w_result = {{(DATA_W-32){1'b0}}, w_diff32};
      OP_AND:   w_result = bus.op1 & bus.op2;
      OP_OR:    w_result = bus.op1 | bus.op2;
      OP_XOR:   w_result = bus.op1 ^ bus.op2;
      OP_NOR:   w_result = ~(bus.op1 | bus.op2);
      OP_SLT:   w_result = {{(DATA_W-1){1'b0}}, ($signed(w_a32) < $signed(w_b32))};
      OP_SLTU:  w_result = {{(DATA_W-1){1'b0}}, (w_a32 < w_b32)};
      OP_SLL:   w_result = {{(DATA_W-32){1'b0}}, w_b32 << bus.shamt};
      OP_SRL:   w_result = {{(DATA_W-32){1'b0}}, w_b32 >> bus.shamt};
      OP_SRA:   w_result = {{(DATA_W-32){1'b0}}, w_sra32};
      OP_SLLV:  w_result = {{(DATA_W-32){1'b0}}, w_b32 << bus.op1[4:0]};
      OP_SRLV:  w_result = {{(DATA_W-32){1'b0}}, w_b32 >> bus.op1[4:0]};
      OP_SRAV:  w_result = {{(DATA_W-32){1'b0}}, w_srav32};
      OP_LUI:   w_result = {{(DATA_W-32){1'b0}}, bus.op2[15:0], 16'h0000};
`ifdef MULT_EN
      OP_MULT:  w_result = w_mulSigned;
      OP_MULTU: w_result = w_mulUnsigned;
`endif
      OP_CMP:   w_result = bus.dbl ? (bus.op1 - bus.op2)
                                   : {{(DATA_W-32){1'b0}}, w_diff32};
      default:  w_result = '0;
    endcase
  end

  assign w_zero   = (w_result == '0);
  assign w_addOvf = (w_a32[31] == w_b32[31]) && (w_sum32[31] != w_a32[31]);
  assign w_subOvf = (w_a32[31] != w_b32[31]) && (w_diff32[31] != w_a32[31]);

  // Holds the last FP compare outcome for bc1t/bc1f; reset wins over a compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpCond <= 1'b0;
    end else if (w_compareOp) begin
      r_fpCond <= w_zero;
    end
  end

  assign bus.result        = w_result;
  assign bus.zero          = w_zero;
  assign bus.overflow      = w_ovfEn && ((w_op == OP_ADD) ? w_addOvf : w_subOvf);
  assign bus.operation     = w_op;
  assign bus.lohi_write    = w_lohiWrite;
  assign bus.lo_read       = w_loRead;
  assign bus.hi_read       = w_hiRead;
  assign bus.compare_op    = w_compareOp;
  assign bus.r_mem_to_reg  = w_memToReg;
  assign bus.read_from_mem = w_readMem;
  assign bus.write_to_mem  = w_writeMem;
  assign bus.branch_addr   = bus.pc_plus4 + (bus.ext_imm << 2);
  assign bus.fp_cond       = r_fpCond;

endmodule

// File: tb/tb_exe_alu_unit.sv
// Self-checking bench for exe_alu_unit: directed cases plus randomized vectors
// scored against an arithmetic reference model. Honours MULT_EN like the design.
module tb_exe_alu_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic expFp;

  exe_alu_if #(.DATA_W(64), .ADDR_W(32)) bus ();

  exe_alu_unit #(.DATA_W(64), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] result;
    logic        zero;
    logic        overflow;
    logic [4:0]  operation;
    logic        lohi;
    logic        lo;
    logic        hi;
    logic        cmp;
    logic        m2r;
    logic        rd;
    logic        wr;
  } exp_t;

  // Reference model straight from the instruction semantics, using wide integer arithmetic.
  function automatic exp_t model(input logic [3:0] aop, input logic [5:0] f, input logic d,
                                 input logic [4:0] sh, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    int op;
    bit ovfEligible;
    longint unsigned mask32;
    longint unsigned ua, ub, r;
    int si, sj;
    longint sa, sb, wide;
    e = '0;
    op = 0;
    ovfEligible = 0;
    mask32 = 64'h0000_0000_FFFF_FFFF;
    ua = a[31:0];
    ub = b[31:0];
    si = a[31:0];
    sj = b[31:0];
    sa = si;
    sb = sj;
    if (aop == 4'd0) begin op = 0; ovfEligible = 1; end
    else if (aop == 4'd1) begin op = 1; ovfEligible = 1; end
    else if (aop == 4'd2) begin
      case (f)
        6'h20: begin op = 0; ovfEligible = 1; end
        6'h22: begin op = 1; ovfEligible = 1; end
        6'h21, 6'h08: op = 0;
        6'h23: op = 1;
        6'h24: op = 2;
        6'h25: op = 3;
        6'h26: op = 4;
        6'h27: op = 5;
        6'h2A: op = 6;
        6'h2B: op = 7;
        6'h00: op = 8;
        6'h02: op = 9;
        6'h03: op = 10;
        6'h04: op = 11;
        6'h06: op = 12;
        6'h07: op = 13;
`ifdef MULT_EN
        6'h18: begin op = 15; e.lohi = 1; end
        6'h19: begin op = 16; e.lohi = 1; end
`endif
        6'h10: e.hi = 1;
        6'h12: e.lo = 1;
        6'h0A: begin e.rd = 1; e.m2r = 1; end
        6'h0B: e.wr = 1;
        default: op = 0;
      endcase
    end
    else if (aop == 4'd3) op = 2;
    else if (aop == 4'd4) op = 3;
    else if (aop == 4'd5) op = 4;
    else if (aop == 4'd6) op = 6;
    else if (aop == 4'd7) op = 7;
    else if (aop == 4'd8) op = 14;
    else if (aop == 4'd9 && f == 6'h32) begin op = 17; e.cmp = 1; end

    case (op)
      0:  r = (ua + ub) & mask32;
      1:  r = (ua - ub) & mask32;
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~(a | b);
      6:  r = (sa < sb) ? 1 : 0;
      7:  r = (ua < ub) ? 1 : 0;
      8:  r = (ub << sh) & mask32;
      9:  r = ub >> sh;
      10: r = longint'(sb >>> sh) & mask32;
      11: r = (ub << a[4:0]) & mask32;
      12: r = ub >> a[4:0];
      13: r = longint'(sb >>> a[4:0]) & mask32;
      14: r = longint'(b[15:0]) * 65536;
      15: r = sa * sb;
      16: r = ua * ub;
      17: r = d ? (a - b) : ((ua - ub) & mask32);
      default: r = 0;
    endcase

    if (ovfEligible) begin
      wide = (op == 0) ? (sa + sb) : (sa - sb);
      e.overflow = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
    end
    e.result    = r;
    e.zero      = (r == 0);
    e.operation = op[4:0];
    return e;
  endfunction

  task automatic setInputs(input logic [3:0] aop, input logic [5:0] f, input logic d,
                           input logic [4:0] sh, input logic [63:0] a, input logic [63:0] b);
    bus.alu_op = aop;
    bus.func   = f;
    bus.dbl    = d;
    bus.shamt  = sh;
    bus.op1    = a;
    bus.op2    = b;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    setInputs(4'd0, 6'h00, 1'b0, 5'd0, 64'd0, 64'd0);
    bus.pc_plus4 = 32'd0;
    bus.ext_imm  = 32'd0;
    @(posedge clk); #1;
    checks++;
    if (bus.fp_cond !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_fp_cond got=%b want=0", bus.fp_cond);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_overflow();
    @(negedge clk);
    setInputs(4'b0010, 6'h20, 1'b0, 5'd0, 64'h7FFF_FFFF, 64'h1);
    checks++;
    if (bus.result !== 64'h0000_0000_8000_0000) begin
      failures++;
      $display("[TB] FAIL add_result got=%h want=0000000080000000", bus.result);
    end
    checks++;
    if (bus.overflow !== 1'b1 || bus.zero !== 1'b0 || bus.operation !== 5'd0) begin
      failures++;
      $display("[TB] FAIL add_flags got ovf=%b zero=%b op=%0d want ovf=1 zero=0 op=0",
               bus.overflow, bus.zero, bus.operation);
    end
    // funct 21 (addu) must never flag overflow
    setInputs(4'b0010, 6'h21, 1'b0, 5'd0, 64'h7FFF_FFFF, 64'h1);
    checks++;
    if (bus.overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL addu_no_ovf got=%b want=0", bus.overflow);
    end
  endtask

  task automatic test_sub_branch();
    @(negedge clk);
    setInputs(4'b0001, 6'h00, 1'b0, 5'd0, 64'd5, 64'd5);
    bus.pc_plus4 = 32'h0000_0100;
    bus.ext_imm  = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (bus.result !== 64'd0 || bus.zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sub_zero got result=%h zero=%b want 0 / 1", bus.result, bus.zero);
    end
    checks++;
    if (bus.branch_addr !== 32'h0000_00FC) begin
      failures++;
      $display("[TB] FAIL branch_addr got=%h want=000000fc", bus.branch_addr);
    end
  endtask

  task automatic test_shift_set();
    @(negedge clk);
    setInputs(4'b0010, 6'h03, 1'b0, 5'd4, 64'd0, 64'h8000_0000);
    checks++;
    if (bus.result !== 64'h0000_0000_F800_0000) begin
      failures++;
      $display("[TB] FAIL sra_result got=%h want=00000000f8000000", bus.result);
    end
    setInputs(4'b0010, 6'h2A, 1'b0, 5'd0, 64'hFFFF_FFFF, 64'h1);
    checks++;
    if (bus.result !== 64'd1) begin
      failures++;
      $display("[TB] FAIL slt_result got=%h want=1", bus.result);
    end
    setInputs(4'b0010, 6'h2B, 1'b0, 5'd0, 64'hFFFF_FFFF, 64'h1);
    checks++;
    if (bus.result !== 64'd0) begin
      failures++;
      $display("[TB] FAIL sltu_result got=%h want=0", bus.result);
    end
  endtask

  task automatic test_mult();
    @(negedge clk);
    setInputs(4'b0010, 6'h18, 1'b0, 5'd0, 64'hFFFF_FFFE, 64'h3);
`ifdef MULT_EN
    checks++;
    if (bus.result !== 64'hFFFF_FFFF_FFFF_FFFA || bus.lohi_write !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mult got result=%h lohi=%b want fffffffffffffffa / 1",
               bus.result, bus.lohi_write);
    end
    setInputs(4'b0010, 6'h19, 1'b0, 5'd0, 64'hFFFF_FFFE, 64'h3);
    checks++;
    if (bus.result !== 64'h0000_0002_FFFF_FFFA || bus.lohi_write !== 1'b1) begin
      failures++;
      $display("[TB] FAIL multu got result=%h lohi=%b want 00000002fffffffa / 1",
               bus.result, bus.lohi_write);
    end
`else
    checks++;
    if (bus.result !== 64'd1 || bus.lohi_write !== 1'b0 || bus.operation !== 5'd0) begin
      failures++;
      $display("[TB] FAIL mult_disabled got result=%h lohi=%b op=%0d want 1 / 0 / 0",
               bus.result, bus.lohi_write, bus.operation);
    end
`endif
  endtask

  task automatic test_fp_cond();
    @(negedge clk);
    setInputs(4'b1001, 6'h32, 1'b0, 5'd0, 64'h3F80_0000, 64'h3F80_0000);
    checks++;
    if (bus.compare_op !== 1'b1 || bus.zero !== 1'b1) begin
      failures++;
      $display("[TB] FAIL cmp_decode got cmp=%b zero=%b want 1 / 1", bus.compare_op, bus.zero);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.fp_cond !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fp_cond_set got=%b want=1", bus.fp_cond);
    end
    @(negedge clk);
    setInputs(4'b0000, 6'h32, 1'b0, 5'd0, 64'h1, 64'h2);
    @(posedge clk); #1;
    checks++;
    if (bus.fp_cond !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fp_cond_hold got=%b want=1", bus.fp_cond);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.fp_cond !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fp_cond_async_reset got=%b want=0", bus.fp_cond);
    end
    // equal compare while held in reset must not set the flag
    setInputs(4'b1001, 6'h32, 1'b1, 5'd0, 64'h55, 64'h55);
    @(posedge clk); #1;
    checks++;
    if (bus.fp_cond !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fp_cond_reset_priority got=%b want=0", bus.fp_cond);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_strobes();
    @(negedge clk);
    setInputs(4'b0010, 6'h0A, 1'b0, 5'd0, 64'd0, 64'd0);
    checks++;
    if (bus.read_from_mem !== 1'b1 || bus.r_mem_to_reg !== 1'b1 || bus.operation !== 5'd0 ||
        bus.write_to_mem !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lwx_strobes got rd=%b m2r=%b wr=%b op=%0d want 1 1 0 0",
               bus.read_from_mem, bus.r_mem_to_reg, bus.write_to_mem, bus.operation);
    end
    setInputs(4'b0010, 6'h0B, 1'b0, 5'd0, 64'd0, 64'd0);
    checks++;
    if (bus.write_to_mem !== 1'b1 || bus.read_from_mem !== 1'b0) begin
      failures++;
      $display("[TB] FAIL swx_strobes got wr=%b rd=%b want 1 0", bus.write_to_mem, bus.read_from_mem);
    end
    setInputs(4'b0010, 6'h10, 1'b0, 5'd0, 64'd0, 64'd0);
    checks++;
    if (bus.hi_read !== 1'b1 || bus.lo_read !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mfhi_strobes got hi=%b lo=%b want 1 0", bus.hi_read, bus.lo_read);
    end
    setInputs(4'b1000, 6'h00, 1'b0, 5'd0, 64'd0, 64'h1234);
    checks++;
    if (bus.result !== 64'h0000_0000_1234_0000 || bus.operation !== 5'd14) begin
      failures++;
      $display("[TB] FAIL lui got result=%h op=%0d want 0000000012340000 / 14",
               bus.result, bus.operation);
    end
  endtask

  task automatic test_random();
    logic [5:0] functs [25];
    logic [3:0] aop;
    logic [5:0] f;
    logic       d;
    logic [4:0] sh;
    logic [63:0] a, b;
    logic [31:0] pc, imm;
    exp_t e, o;
    functs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h18, 6'h19, 6'h10,
               6'h12, 6'h0A, 6'h0B, 6'h32, 6'h3F};
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    expFp = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      aop = 4'($urandom_range(0, 15));
      f   = ($urandom_range(0, 4) == 0) ? 6'($urandom) : functs[$urandom_range(0, 24)];
      if (aop == 4'd9 && $urandom_range(0, 1) == 1) f = 6'h32;
      d   = 1'($urandom);
      sh  = 5'($urandom);
      a   = {$urandom, $urandom};
      b   = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) a[31:0] = 32'h7FFF_FFFF;
      pc  = $urandom;
      imm = $urandom;
      bus.pc_plus4 = pc;
      bus.ext_imm  = imm;
      setInputs(aop, f, d, sh, a, b);
      e = model(aop, f, d, sh, a, b);
      o.result    = bus.result;
      o.zero      = bus.zero;
      o.overflow  = bus.overflow;
      o.operation = bus.operation;
      o.lohi      = bus.lohi_write;
      o.lo        = bus.lo_read;
      o.hi        = bus.hi_read;
      o.cmp       = bus.compare_op;
      o.m2r       = bus.r_mem_to_reg;
      o.rd        = bus.read_from_mem;
      o.wr        = bus.write_to_mem;
      checks++;
      if (o !== e) begin
        failures++;
        $display("[TB] FAIL random_alu aop=%h f=%h d=%b a=%h b=%h got=%h want=%h",
                 aop, f, d, a, b, o, e);
      end
      checks++;
      if (bus.branch_addr !== 32'(pc + imm * 4)) begin
        failures++;
        $display("[TB] FAIL random_branch got=%h want=%h", bus.branch_addr, 32'(pc + imm * 4));
      end
      if (e.cmp) expFp = e.zero;
      @(posedge clk); #1;
      checks++;
      if (bus.fp_cond !== expFp) begin
        failures++;
        $display("[TB] FAIL random_fp_cond got=%b want=%b", bus.fp_cond, expFp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    expFp    = 1'b0;
    rst_n    = 1'b1;
    test_reset();
    test_add_overflow();
    test_sub_branch();
    test_shift_set();
    test_mult();
    test_fp_cond();
    test_strobes();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exe_alu_unit.md
Name: exe_alu_unit

Overview:
Execute-stage arithmetic block of the 5-stage MIPS pipeline. It combines three functions:
- ALU-control decoding: ALUop plus funct field into a 5-bit operation and side-band strobes.
- The 64-bit-datapath ALU.
- The branch-target adder.

It also holds the floating-point compare condition flag used by bc1t/bc1f. It sits between ID_EXE and EXE_MEM pipeline registers; everything is combinational except fp_cond.

Parameters:
DATA_W, 64, operand/result width (32-bit ops use the low half)
ADDR_W, 32, PC/branch address width

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
alu_op  in  4  ALUop from control unit
func  in  6  instruction funct field
dbl  in  1  double-precision/64-bit compare select
shamt  in  5  shift amount field
op1  in  64  operand A (rs / forwarded)
op2  in  64  operand B (rt / immediate / forwarded)
pc_plus4  in  32  PC+4 of instruction in EXE
ext_imm  in  32  extended immediate
result  out  64  ALU result
zero  out  1  result == 0 (full 64 bits)
overflow  out  1  signed 32-bit add/sub overflow
operation  out  5  decoded ALU operation
lohi_write  out  1  mult/multu writes Lo/Hi
lo_read  out  1  mflo
hi_read  out  1  mfhi
compare_op  out  1  FP compare instruction
r_mem_to_reg  out  1  register-indexed load writes back memory data
read_from_mem  out  1  register-indexed load (lwx)
write_to_mem  out  1  register-indexed store (swx)
branch_addr  out  32  pc_plus4 + (ext_imm << 2)
fp_cond  out  1  registered FP condition flag

Behaviour:

ALUop decode:
- 0000 ADD, 0001 SUB, 0010 R-type (funct), 0011 AND, 0100 OR, 0101 XOR, 0110 SLT, 0111 SLTU, 1000 LUI, 1001 FP (funct), others ADD.

Operation codes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 SLLV, 12 SRLV, 13 SRAV, 14 LUI, 15 MULT, 16 MULTU, 17 CMP.

R-type funct (hex):
- 20/21 ADD; 22/23 SUB; 24 AND; 25 OR; 26 XOR; 27 NOR; 2A SLT; 2B SLTU.
- 00 SLL; 02 SRL; 03 SRA; 04 SLLV; 06 SRLV; 07 SRAV.
- 08 (jr) ADD.
- 18 MULT + lohi_write; 19 MULTU + lohi_write.
- 10 ADD + hi_read; 12 ADD + lo_read.
- 0A ADD + read_from_mem + r_mem_to_reg; 0B ADD + write_to_mem.
- Unlisted funct: ADD, all strobes 0.

FP funct:
- 32 (c.eq) → CMP + compare_op.
- Any other FP funct → ADD, no strobes.

Strobes are 0 whenever not listed for the current decode.

Arithmetic, logic, set and LUI (op1 = rs, op2 = rt/imm):
- Logical ops act on all 64 bits.
- ADD/SUB/SLT/SLTU/LUI/shifts compute on bits [31:0]; the upper 32 result bits are zero.
- SLT/SLTU: result 1 or 0.
- LUI: {op2[15:0], 16'h0}.

Shifts:
- SLL/SRL/SRA shift op2[31:0] by shamt.
- The variable forms (SLLV/SRLV/SRAV) shift by op1[4:0].

Multiply:
- MULT: signed 32x32 of the low halves, full 64-bit product.
- MULTU: the same product, unsigned.
- Lo = result[31:0], Hi = result[63:32].

Compare:
- CMP: result = op1 − op2 over 64 bits when dbl=1, over the low 32 bits (zero-extended) when dbl=0.
- Equal operands give zero=1.

Overflow:
- Set only for ADD/SUB from funct 20/22 or ALUop 0000/0001.
- Condition is signed 32-bit overflow; 0 otherwise.

Branch adder:
- branch_addr = pc_plus4 + {ext_imm[29:0], 2'b00}, modulo 2^32.

fp_cond:
- Async reset to 0.
- On posedge clk, if compare_op=1, fp_cond <= zero; otherwise it holds.
- The new value is visible the cycle after the compare.
- Reset has priority over a simultaneous compare.

All combinational outputs follow inputs within the same cycle and are unaffected by reset.

Optional Feature:
MULT_EN defined: MULT/MULTU implemented as above.
MULT_EN undefined:
- funct 18/19 decode to ADD with lohi_write=0.
- Operation codes 15/16 are never generated.
- No multiplier is synthesized.

Test Plan:
1. alu_op=0010, func=20, op1=7FFFFFFF, op2=1 → result=0000000080000000, overflow=1, zero=0, operation=0.
2. alu_op=0001, op1=op2=5 → result=0, zero=1; pc_plus4=00000100, ext_imm=FFFFFFFF → branch_addr=000000FC.
3. alu_op=0010, func=03, shamt=4, op2=80000000 → result=00000000F8000000; func=2A, op1=FFFFFFFF, op2=1 → result=1; func=2B → result=0.
4. alu_op=0010, func=18, op1=FFFFFFFE, op2=3 → result=FFFFFFFFFFFFFFFA, lohi_write=1; func=19 → result=00000002FFFFFFFA (MULT_EN defined); MULT_EN undefined → result=1, lohi_write=0.
5. alu_op=1001, func=32, dbl=0, op1=op2=3F800000 → compare_op=1, zero=1; fp_cond=1 after next edge. Then operands unequal with compare_op=0 → fp_cond holds 1. Assert rst_n=0 mid-cycle → fp_cond=0 immediately.
6. alu_op=0010, func=0A → read_from_mem=1, r_mem_to_reg=1, operation=0; func=0B → write_to_mem=1; func=10 → hi_read=1; alu_op=1000, op2=1234 → result=12340000.
